// File: rtl/riscv_imem_loader.sv
// riscv_imem_loader: assembles RV32I words from mnemonic/field tuples and
// writes them into instruction memory from word 0 upward. The core is held in
// reset until the program is loaded.
// Optional feature macro: IMEM_NOP_PAD_EN (pad the rest of imem with NOPs).
module riscv_imem_loader #(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              full,
    output logic              err_illegal
);

    typedef enum logic [2:0] {ST_IDLE, ST_ENC, ST_WR, ST_PAD, ST_DONE} state_t;

    localparam logic [6:0]        OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]        OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]        OPC_STORE  = 7'b0100011;
    localparam logic [6:0]        OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]        OPC_OP     = 7'b0110011;
    localparam logic [31:0]       NOP_WORD   = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMEM_DEPTH - 1);

    // Instruction formats as seen by the encoder
    localparam logic [2:0] K_B = 3'd0, K_L = 3'd1, K_S = 3'd2, K_I = 3'd3,
                           K_SH = 3'd4, K_R = 3'd5, K_ILL = 3'd7;

    // Returns {legal, machine_word}; unknown op codes come back with legal=0.
    function automatic logic [32:0] encode_rv32i(
        input logic [5:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [12:0] imm
    );
        logic [2:0]  kind;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] word;
        logic        legal;
        kind = K_ILL;
        f3   = 3'b000;
        f7   = 7'b0000000;
        case (op)
            6'd0:  begin kind = K_B;  f3 = 3'b000; end
            6'd1:  begin kind = K_B;  f3 = 3'b001; end
            6'd2:  begin kind = K_B;  f3 = 3'b100; end
            6'd3:  begin kind = K_B;  f3 = 3'b101; end
            6'd4:  begin kind = K_B;  f3 = 3'b110; end
            6'd5:  begin kind = K_B;  f3 = 3'b111; end
            6'd6:  begin kind = K_L;  f3 = 3'b000; end
            6'd7:  begin kind = K_L;  f3 = 3'b001; end
            6'd8:  begin kind = K_L;  f3 = 3'b010; end
            6'd9:  begin kind = K_L;  f3 = 3'b100; end
            6'd10: begin kind = K_L;  f3 = 3'b101; end
            6'd11: begin kind = K_S;  f3 = 3'b000; end
            6'd12: begin kind = K_S;  f3 = 3'b001; end
            6'd13: begin kind = K_S;  f3 = 3'b010; end
            6'd14: begin kind = K_I;  f3 = 3'b000; end
            6'd15: begin kind = K_I;  f3 = 3'b010; end
            6'd16: begin kind = K_I;  f3 = 3'b011; end
            6'd17: begin kind = K_I;  f3 = 3'b100; end
            6'd18: begin kind = K_I;  f3 = 3'b110; end
            6'd19: begin kind = K_I;  f3 = 3'b111; end
            6'd20: begin kind = K_SH; f3 = 3'b001; end
            6'd21: begin kind = K_SH; f3 = 3'b101; end
            6'd22: begin kind = K_SH; f3 = 3'b101; f7 = 7'b0100000; end
            6'd23: begin kind = K_R;  f3 = 3'b000; end
            6'd24: begin kind = K_R;  f3 = 3'b000; f7 = 7'b0100000; end
            6'd25: begin kind = K_R;  f3 = 3'b001; end
            6'd26: begin kind = K_R;  f3 = 3'b010; end
            6'd27: begin kind = K_R;  f3 = 3'b011; end
            6'd28: begin kind = K_R;  f3 = 3'b100; end
            6'd29: begin kind = K_R;  f3 = 3'b101; end
            6'd30: begin kind = K_R;  f3 = 3'b101; f7 = 7'b0100000; end
            6'd31: begin kind = K_R;  f3 = 3'b110; end
            6'd32: begin kind = K_R;  f3 = 3'b111; end
            default: begin kind = K_ILL; f3 = 3'b000; end
        endcase
        legal = 1'b1;
        case (kind)
            K_B:  word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
            K_L:  word = {imm[11:0], rs1, f3, rd, OPC_LOAD};
            K_S:  word = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
            K_I:  word = {imm[11:0], rs1, f3, rd, OPC_OPIMM};
            K_SH: word = {f7, imm[4:0], rs1, f3, rd, OPC_OPIMM};
            K_R:  word = {f7, rs2, rs1, f3, rd, OPC_OP};
            default: begin
                word  = 32'h0000_0000;
                legal = 1'b0;
            end
        endcase
        return {legal, word};
    endfunction

    state_t              state_r, state_s;
    logic [5:0]          op_r, op_s;
    logic [4:0]          rd_r, rd_s, rs1_r, rs1_s, rs2_r, rs2_s;
    logic [12:0]         imm_r, imm_s;
    logic                last_r, last_s;
    logic                in_ready_r, in_ready_s;
    logic                we_r, we_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [31:0]         wdata_r, wdata_s;
    logic                core_hold_r, core_hold_s;
    logic                done_r, done_s;
    logic                full_r, full_s;
    logic                err_r, err_s;
    logic [32:0]         enc_s;

    // Next-state and next-output computation for the load sequencer
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        rd_s        = rd_r;
        rs1_s       = rs1_r;
        rs2_s       = rs2_r;
        imm_s       = imm_r;
        last_s      = last_r;
        we_s        = 1'b0;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        full_s      = full_r;
        err_s       = err_r;
        enc_s       = encode_rv32i(op_r, rd_r, rs1_r, rs2_r, imm_r);
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    op_s    = in_op;
                    rd_s    = in_rd;
                    rs1_s   = in_rs1;
                    rs2_s   = in_rs2;
                    imm_s   = in_imm;
                    last_s  = in_last;
                    state_s = ST_ENC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ENC: begin
                if (enc_s[32]) begin
                    wdata_s = enc_s[31:0];
                    we_s    = 1'b1;
                    state_s = ST_WR;
                end else begin
                    // Illegal op: flag it, skip the write, keep the address
                    err_s   = 1'b1;
                    state_s = last_r ? ST_DONE : ST_IDLE;
                end
            end
            ST_WR: begin
                if (addr_r == LAST_ADDR) begin
                    full_s  = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    addr_s = addr_r + ADDR_W'(1);
                    if (last_r) begin
`ifdef IMEM_NOP_PAD_EN
                        we_s    = 1'b1;
                        wdata_s = NOP_WORD;
                        state_s = ST_PAD;
`else
                        state_s = ST_DONE;
`endif
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
            end
`ifdef IMEM_NOP_PAD_EN
            ST_PAD: begin
                if (addr_r == LAST_ADDR) begin
                    full_s  = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    addr_s  = addr_r + ADDR_W'(1);
                    we_s    = 1'b1;
                    wdata_s = NOP_WORD;
                    state_s = ST_PAD;
                end
            end
`endif
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        in_ready_s  = (state_s == ST_IDLE);
        done_s      = (state_s == ST_DONE);
        core_hold_s = (state_s != ST_DONE);
    end

    // State and registered-output update, async reset to the idle/hold state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op_r        <= 6'd0;
            rd_r        <= 5'd0;
            rs1_r       <= 5'd0;
            rs2_r       <= 5'd0;
            imm_r       <= 13'd0;
            last_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            core_hold_r <= 1'b1;
            done_r      <= 1'b0;
            full_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            rd_r        <= rd_s;
            rs1_r       <= rs1_s;
            rs2_r       <= rs2_s;
            imm_r       <= imm_s;
            last_r      <= last_s;
            in_ready_r  <= in_ready_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            core_hold_r <= core_hold_s;
            done_r      <= done_s;
            full_r      <= full_s;
            err_r       <= err_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign imem_we     = we_r;
    assign imem_addr   = addr_r;
    assign imem_wdata  = wdata_r;
    assign core_hold   = core_hold_r;
    assign done        = done_r;
    assign full        = full_r;
    assign err_illegal = err_r;

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Scoreboard bench for riscv_imem_loader (IMEM_DEPTH=4). Expected imem
// writes are queued when a tuple is issued; a monitor pops on every imem_we.
module tb_riscv_imem_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [5:0]    in_op = 6'd0;
    logic [4:0]    in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
    logic [12:0]   in_imm = 13'd0;
    logic          in_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold, done, full, err_illegal;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];

`ifdef IMEM_NOP_PAD_EN
    localparam logic PAD = 1'b1;
`else
    localparam logic PAD = 1'b0;
`endif

    riscv_imem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_hold(core_hold),
        .done(done), .full(full), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", imem_addr, imem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), e[63:32]);
                check("wr_data", imem_wdata, e[31:0]);
            end
        end
    end

    task automatic expect_wr(input int addr, input logic [31:0] data);
        exp_q.push_back({32'(addr), data});
    endtask

    // With padding enabled, the unwritten tail fills with NOPs
    task automatic expect_tail(input int from);
        if (PAD) begin
            for (int a = from; a < DEPTH; a++) expect_wr(a, 32'h0000_0013);
        end
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [12:0] imm, input logic last);
        int budget;
        budget = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL handshake_timeout: in_ready %b required 1", in_ready);
        end
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int budget;
        budget = 0;
        while (done !== 1'b1 && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        check(name, 32'(done), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check({name, "_flags"}, {25'd0, in_ready, imem_we, core_hold, done, full, err_illegal, 1'b0},
              {25'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check({name, "_addr"}, 32'(imem_addr), 32'd0);
        check({name, "_wdata"}, imem_wdata, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // S1: ADDI x1,x0,5 alone, latency of two cycles to the write strobe
        do_reset("rst1");
        expect_wr(0, 32'h0050_0093);
        expect_tail(1);
        send(6'd14, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
        @(negedge clk);
        check("lat_c1_we_ready", {30'd0, imem_we, in_ready}, 32'd0);
        @(negedge clk);
        check("lat_c2_we", 32'(imem_we), 32'd1);
        wait_done("s1_done");
        check("s1_hold_ready", {30'd0, core_hold, in_ready}, 32'd0);
        check("s1_full", 32'(full), 32'(PAD));

        // S2: ADD then SUB, in_ready low for two cycles after handshake
        do_reset("rst2");
        expect_wr(0, 32'h0020_81B3);
        expect_wr(1, 32'h4020_81B3);
        expect_tail(2);
        send(6'd23, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        @(negedge clk);
        check("s2_ready_c1", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("s2_ready_c2", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("s2_ready_c3", 32'(in_ready), 32'd1);
        send(6'd24, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1);
        wait_done("s2_done");
        check("s2_full", 32'(full), 32'(PAD));

        // S3: SW, BEQ, SRAI encodings
        do_reset("rst3");
        expect_wr(0, 32'h0020_A423);
        expect_wr(1, 32'h0020_8463);
        expect_wr(2, 32'h4032_D293);
        expect_tail(3);
        send(6'd13, 5'd0, 5'd1, 5'd2, 13'd8, 1'b0);
        send(6'd0, 5'd0, 5'd1, 5'd2, 13'd8, 1'b0);
        send(6'd22, 5'd5, 5'd5, 5'd0, 13'h1FE3, 1'b1);
        wait_done("s3_done");

        // S4: illegal op with last=0, then a legal one still lands at addr 0
        do_reset("rst4");
        send(6'd40, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("s4_err", 32'(err_illegal), 32'd1);
        check("s4_ready", 32'(in_ready), 32'd1);
        expect_wr(0, 32'h0050_0093);
        expect_tail(1);
        send(6'd14, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
        wait_done("s4_done");
        check("s4_err_sticky", 32'(err_illegal), 32'd1);

        // S5: four writes without last fill imem; DONE ignores in_valid
        do_reset("rst5");
        expect_wr(0, 32'h00C1_2203);
        expect_wr(1, 32'hFE20_9EE3);
        expect_wr(2, 32'h01F3_9313);
        expect_wr(3, 32'hFE53_0FA3);
        send(6'd8, 5'd4, 5'd2, 5'd0, 13'd12, 1'b0);
        send(6'd1, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b0);
        send(6'd20, 5'd6, 5'd7, 5'd0, 13'h1FFF, 1'b0);
        send(6'd11, 5'd0, 5'd6, 5'd5, 13'h1FFF, 1'b0);
        wait_done("s5_done");
        check("s5_state", {28'd0, full, done, core_hold, in_ready}, 32'b1100);
        check("s5_addr_nowrap", 32'(imem_addr), 32'd3);
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check("s5_done_absorb", {30'd0, done, in_ready}, 32'b10);

        // S6: reset asserted during WR aborts, then reload from addr 0
        do_reset("rst6");
        expect_wr(0, 32'h0050_0093);
        send(6'd14, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("s6_we", 32'(imem_we), 32'd0);
        check("s6_addr", 32'(imem_addr), 32'd0);
        check("s6_hold_ready", {30'd0, core_hold, in_ready}, 32'b11);
        @(negedge clk);
        reset = 1'b0;
        expect_wr(0, 32'h4032_D293);
        expect_tail(1);
        send(6'd22, 5'd5, 5'd5, 5'd0, 13'd3, 1'b1);
        wait_done("s6_done");

        // S7: illegal op carrying last goes straight to DONE, nothing written
        do_reset("rst7");
        send(6'd63, 5'd0, 5'd0, 5'd0, 13'd0, 1'b1);
        wait_done("s7_done");
        check("s7_err_full", {30'd0, err_illegal, full}, 32'b10);

        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
